ad9228_fifo_drain: RTL and testbench

AD9228_FIFO_DRAIN -- requirements
Module: ad9228_fifo_drain

---
 rtl/ad9228_fifo_drain.sv | 112 +++++++++++
 tb/tb_ad9228_fifo_drain.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9228_fifo_drain.sv
// ad9228_fifo_drain: round-robin drain of per-channel ADC sample FIFOs into a 32-bit stream.
// Define AD9228_DRAIN_OVF_EN to build the sticky per-channel overflow flags.
module ad9228_fifo_drain #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    output logic [$clog2(NUM_CHANNELS)-1:0] fifo_addr,
    output logic [NUM_CHANNELS-1:0]         fifo_rd_en,
    input  logic                            fifo_not_empty,
    input  logic                            fifo_full,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    output logic [31:0]                     m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [NUM_CHANNELS-1:0]         overflow,
    input  logic                            overflow_clr
);

    localparam int AW = $clog2(NUM_CHANNELS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] LATCH  = 3'd3;
    localparam logic [2:0] SEND   = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] ch;
    logic [AW-1:0] ch_next;
    logic [7:0]    seq;
    logic [7:0]    burst_cnt;

    // The channel register drives the upstream mux select directly.
    assign fifo_addr = ch;
    assign ch_next   = (ch == AW'(NUM_CHANNELS - 1)) ? '0 : ch + AW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            ch         <= '0;
            seq        <= '0;
            burst_cnt  <= '0;
            fifo_rd_en <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
        end else begin
            fifo_rd_en <= '0;
            case (state)
                IDLE: begin
                    if (enable) state <= SELECT;
                end
                SELECT: begin
                    state <= enable ? READ : IDLE;
                end
                READ: begin
                    if (enable && fifo_not_empty) begin
                        fifo_rd_en[ch] <= 1'b1;
                        state          <= LATCH;
                    end else begin
                        if (!fifo_not_empty) ch <= ch_next;
                        state <= enable ? SELECT : IDLE;
                    end
                end
                // Read strobe is high this cycle; the mux shows the read word and post-read level.
                LATCH: begin
                    m_tdata  <= {seq, 8'(ch), 16'(fifo_dout)};
                    m_tlast  <= (burst_cnt == 8'(BURST_LEN - 1)) || !fifo_not_empty;
                    m_tvalid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (m_tready) begin
                        m_tvalid <= 1'b0;
                        seq      <= seq + 8'd1;
                        if (m_tlast || !enable) begin
                            burst_cnt <= '0;
                            ch        <= ch_next;
                            state     <= enable ? SELECT : IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                            state     <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AD9228_DRAIN_OVF_EN
    // A full seen this cycle survives a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= '0;
        end else begin
            overflow <= (overflow_clr ? '0 : overflow)
                      | (fifo_full ? (NUM_CHANNELS'(1) << ch) : '0);
        end
    end
`else
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = &{1'b0, fifo_full, overflow_clr};
    assign overflow          = '0;
`endif

endmodule

// File: tb/tb_ad9228_fifo_drain.sv
// Scoreboard bench for ad9228_fifo_drain: queue-based upstream FIFO model and a stream reference model.
// Overflow checks follow AD9228_DRAIN_OVF_EN as the DUT is built.
module tb_ad9228_fifo_drain;

    localparam int NCH   = 4;
    localparam int DW    = 12;
    localparam int BURST = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            enable;
    logic [1:0]      fifo_addr;
    logic [NCH-1:0]  fifo_rd_en;
    logic            fifo_not_empty;
    logic            fifo_full;
    logic [DW-1:0]   fifo_dout;
    logic [31:0]     m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [NCH-1:0]  overflow;
    logic            overflow_clr;

    int vectors     = 0;
    int miscompares = 0;
    int hs_count    = 0;
    int rdy_mode    = 0;

    logic [32:0] exp_q[$];

    logic [DW-1:0] mem [NCH][256];
    logic [7:0]    wr_ptr [NCH] = '{default: 8'd0};
    logic [7:0]    rd_ptr [NCH] = '{default: 8'd0};

    always #5 clk = ~clk;

    ad9228_fifo_drain #(
        .NUM_CHANNELS(NCH),
        .DATA_WIDTH  (DW),
        .BURST_LEN   (BURST)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .fifo_addr     (fifo_addr),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_not_empty(fifo_not_empty),
        .fifo_full     (fifo_full),
        .fifo_dout     (fifo_dout),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    // Upstream FIFO: while the strobe is high the mux shows the word being read and the post-read level.
    assign fifo_dout      = mem[fifo_addr][rd_ptr[fifo_addr]];
    assign fifo_not_empty = (8'(wr_ptr[fifo_addr] - rd_ptr[fifo_addr]) > ((fifo_rd_en != '0) ? 8'd1 : 8'd0));

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++)
            if (fifo_rd_en[c]) rd_ptr[c] <= rd_ptr[c] + 8'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load(input int c, input logic [DW-1:0] d);
        mem[c][wr_ptr[c]] = d;
        wr_ptr[c] = wr_ptr[c] + 8'd1;
    endtask

    // Reference: visit channels round-robin from 0, take min(BURST, level) per visit, tlast on the visit's final word.
    task automatic build_expected(input int limit);
        int unsigned c, sq, total, take;
        int          produced;
        int unsigned rem [NCH];
        logic [7:0]  pos [NCH];
        c = 0; sq = 0; total = 0; produced = 0;
        for (int i = 0; i < NCH; i++) begin
            rem[i] = 32'(8'(wr_ptr[i] - rd_ptr[i]));
            pos[i] = rd_ptr[i];
            total += rem[i];
        end
        while (total > 0 && (limit < 0 || produced < limit)) begin
            if (rem[c] != 0) begin
                take = (rem[c] < BURST) ? rem[c] : BURST;
                for (int unsigned k = 0; k < take && (limit < 0 || produced < limit); k++) begin
                    exp_q.push_back({sq[7:0], 8'(c), 16'(mem[c][pos[c]]), (k == take - 1)});
                    pos[c] = pos[c] + 8'd1;
                    rem[c]--; total--; sq++; produced++;
                end
            end
            c = (c + 1) % NCH;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rstn   = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " fifo_addr"}, 64'(fifo_addr), 64'd0);
        chk({name, " fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({name, " m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({name, " m_tlast"}, 64'(m_tlast), 64'd0);
        chk({name, " m_tdata"}, 64'(m_tdata), 64'd0);
        chk({name, " overflow"}, 64'(overflow), 64'd0);
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 99) < 60);
                default: m_tready = 1'b0;
            endcase
        end
    endtask

    task automatic monitor_loop();
        logic [31:0] pd;
        logic        pl;
        logic        stalled;
        logic [32:0] e;
        stalled = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 1'b0;
                continue;
            end
            vectors++;
            if (!(fifo_rd_en == '0 || fifo_rd_en == (NCH'(1) << fifo_addr)) || (m_tvalid && fifo_rd_en != '0)) begin
                miscompares++;
                $display("FAIL rd_en strobe: got %b (addr %0d, tvalid %0b), required zero or one-hot on addr outside SEND",
                         fifo_rd_en, fifo_addr, m_tvalid);
            end
            if (stalled) begin
                vectors++;
                if (!m_tvalid || m_tdata !== pd || m_tlast !== pl) begin
                    miscompares++;
                    $display("FAIL stall hold: got valid %0b data %h last %0b, required valid 1 data %h last %0b",
                             m_tvalid, m_tdata, m_tlast, pd, pl);
                end
            end
            if (m_tvalid && m_tready) begin
                hs_count++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected word: got data %h last %0b, required no word", m_tdata, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tdata, m_tlast} !== e) begin
                        miscompares++;
                        $display("FAIL stream word: got data %h last %0b, required data %h last %0b",
                                 m_tdata, m_tlast, e[32:1], e[0]);
                    end
                end
            end
            stalled = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
        end
    endtask

    initial begin
        int base;
        bit found;
        rstn = 1'b0; enable = 1'b0; fifo_full = 1'b0; overflow_clr = 1'b0; m_tready = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 256; i++) mem[c][i] = '0;
        fork
            monitor_loop();
            ready_loop();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Three samples on channel 0, constants from the documented example
        do_reset();
        load(0, 12'h111); load(0, 12'h222); load(0, 12'h333);
        exp_q.push_back({32'h0000_0111, 1'b0});
        exp_q.push_back({32'h0100_0222, 1'b0});
        exp_q.push_back({32'h0200_0333, 1'b1});
        rdy_mode = 0;
        enable = 1'b1;
        wait_drain("ch0 three", 200);
        @(negedge clk);
        chk("ch advance after burst", 64'(fifo_addr), 64'd1);

        // 20 samples on channel 2: burst split at BURST
        do_reset();
        for (int i = 0; i < 20; i++) load(2, 12'($urandom));
        build_expected(-1);
        enable = 1'b1;
        wait_drain("ch2 split", 500);

        // Ten-cycle ready stall mid SEND
        do_reset();
        for (int i = 0; i < 6; i++) load(3, 12'($urandom));
        build_expected(-1);
        rdy_mode = 2;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (m_tvalid) found = 1;
        end
        chk("stall reach SEND", 64'(found), 64'd1);
        repeat (10) @(negedge clk);
        rdy_mode = 0;
        wait_drain("stall", 500);

        // enable dropped during SEND of word 5
        do_reset();
        for (int i = 0; i < 10; i++) load(1, 12'($urandom));
        build_expected(5);
        base = hs_count;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (hs_count - base == 5) found = 1;
        end
        chk("word5 reached", 64'(found), 64'd1);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no read after disable", 64'(fifo_rd_en), 64'd0);
        end
        chk("words after disable", 64'(hs_count - base), 64'd5);
        chk("queue after disable", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset during LATCH
        do_reset();
        for (int i = 0; i < 5; i++) load(0, 12'($urandom));
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en != '0) found = 1;
        end
        chk("reach LATCH", 64'(found), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset in LATCH");
        build_expected(-1);
        rstn = 1'b1;
        wait_drain("after LATCH reset", 1000);

        // Randomized rounds with random backpressure
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < NCH; c++) begin
                int n = $urandom_range(0, 40);
                for (int i = 0; i < n; i++) load(c, 12'($urandom));
            end
            build_expected(-1);
            rdy_mode = 1;
            enable = 1'b1;
            wait_drain("random", 5000);
            rdy_mode = 0;
        end

        // Overflow flags
        do_reset();
        build_expected(-1);
        enable = 1'b1;
`ifdef AD9228_DRAIN_OVF_EN
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (fifo_addr == 2'd1) found = 1;
        end
        chk("overflow addr 1 seen", 64'(found), 64'd1);
        fifo_full = 1'b1; overflow_clr = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0; overflow_clr = 1'b0;
        chk("overflow set wins", 64'(overflow), 64'h2);
        repeat (5) @(negedge clk);
        chk("overflow sticky", 64'(overflow), 64'h2);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("overflow cleared", 64'(overflow), 64'h0);
`else
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            overflow_clr = i[0];
            @(negedge clk);
            chk("overflow disabled", 64'(overflow), 64'h0);
        end
        fifo_full = 1'b0; overflow_clr = 1'b0;
`endif
        enable = 1'b0;
        wait_drain("overflow phase", 100);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
